mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM, with 1-cycle read latency and byte write mask, between two requesters.
- Master 0 is the multicycle RISC-V core, via a req/gnt wrapper. Master 1 is a DMA engine, e.g. a framebuffer scan-out.
- Per-cycle grant with read-response routing, a lock mechanism so master 1 can run bursts, and a bounded lock length so the core is never starved.

Parameters:
- AW, 32, address width.
- DW, 32, data width; mask width is DW/8.
- MAX_LOCK, 16, maximum consecutive master-1 grants under lock before a forced release.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 access request.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  AW  master 0 byte address.
- m0_wdata  in  DW  master 0 write data, lane-aligned.
- m0_wmask  in  DW/8  master 0 byte write mask.
- m0_gnt  out  1  master 0 access accepted this cycle.
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DW  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_wmask, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- m1_lock  in  1  master 1 requests to keep ownership after this grant.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_we  out  1  RAM write strobe.
- mem_wmask  out  DW/8  RAM byte enables.
- mem_rdata  in  DW  RAM read data, valid the cycle after the address.

Behaviour:
- Reset (reset=0, async): state=IDLE, lock_cnt=0, rsp_valid=0, rsp_id=0, rr_last=1.
- Outputs during reset: all gnt/rvalid=0, mem_we=0, mem_wmask=0. In-flight read response is discarded.
- Grant:
  - Combinational, at most one per cycle; mX_gnt=1 only if mX_req=1.
  - Request fields must be held stable until gnt.
- Memory side:
  - mem_* is muxed from the granted master.
  - With no grant: mem_we=0, mem_wmask=0, mem_addr=m0_addr, mem_wdata=0.
  - mem_we = granted mX_we; mem_wmask = granted mX_wmask when we=1, else 0.
- Read response:
  - A read grant in cycle T registers rsp_valid=1 and rsp_id=X.
  - In T+1: mX_rvalid=1 and mX_rdata=mem_rdata.
  - Both rdata ports always carry mem_rdata; only rvalid is routed.
  - Back-to-back grants are allowed every cycle. Writes produce no response.
- State machine:
  - IDLE: default priority applies (fixed m0 > m1). A m1 grant with m1_lock=1 moves to LOCK1 and sets lock_cnt=1.
  - LOCK1: only m1 may be granted; m0_gnt=0.
    - Each m1 grant increments lock_cnt.
    - A m1 grant with m1_lock=0 returns to IDLE.
    - m1_req=0 for one cycle returns to IDLE.
    - lock_cnt==MAX_LOCK with m1 granted forces RELEASE, whatever m1_lock says.
  - RELEASE: for exactly one cycle, m0 has absolute priority. If m0_req=0, m1 may be granted, but its lock is ignored. Then go to IDLE; lock_cnt=0.
- Simultaneous events:
  - m0_req and m1_req in IDLE: m0 wins (fixed mode).
  - m1 lock grant in the same cycle as a prior read response: the response is still delivered.
- lock_cnt saturates at MAX_LOCK; it never wraps.

Optional Feature:
- MEM_ARB_RR_EN defined: IDLE uses round-robin. On a conflict, the master not in rr_last wins. rr_last updates on every grant in any state.
- Undefined: fixed priority m0 > m1, and rr_last is unused.
- LOCK1 and RELEASE behave the same either way.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, LOCK1, RELEASE}.
  - master_id_t (1 bit).
  - Constants M_CPU=0, M_DMA=1.
- Sub-module arb_pick: combinational picker taking (req0, req1, mode/rr_last, mask0, mask1) and returning gnt0/gnt1. It holds the fixed/RR choice.

Test Plan:
- Read m0 only: m0 reads 0x100, RAM word 0xDEADBEEF → m0_gnt at T, m0_rvalid at T+1 with rdata 0xDEADBEEF, m1_rvalid=0.
- Conflict: m0 and m1 request the same cycle in IDLE (fixed mode) → m0_gnt=1, m1_gnt=0; next cycle m1_gnt=1.
- Lock burst: m1_lock=1 for 4 reads from 0x2000 while m0_req=1 → 4 consecutive m1_gnt; m0_gnt on the 5th cycle after lock drops.
- Lock bound: MAX_LOCK=16, m1_lock held with m0 requesting:
  - 16 m1 grants, then RELEASE with m0_gnt=1;
  - m1 is regranted after.
- Byte write: m1 sb, wdata 0x0000AB00, wmask 0010 → mem_we=1, mem_wmask=0010, no rvalid.
- Reset during an in-flight read: reset=0 in T+1 → m0_rvalid stays 0; after reset, state=IDLE.
- MEM_ARB_RR_EN build: both masters continuously request → grants alternate 0,1,0,1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master RAM arbiter (CPU on master 0, DMA on master 1).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK1   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t M_CPU = 1'b0;
  localparam master_id_t M_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational two-way picker: fixed m0 > m1 priority, or round-robin against rr_last_i.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       rr_mode_i,
  input  master_id_t rr_last_i,
  input  logic       mask0_i,
  input  logic       mask1_i,
  output logic       gnt0_o,
  output logic       gnt1_o
);

  logic req0_s;
  logic req1_s;

  assign req0_s = req0_i & mask0_i;
  assign req1_s = req1_i & mask1_i;

  // On a conflict round-robin favours whichever master was not granted last
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_s && req1_s) begin
      if (rr_mode_i && (rr_last_i == M_CPU)) begin
        gnt1_o = 1'b1;
      end else begin
        gnt0_o = 1'b1;
      end
    end else begin
      gnt0_o = req0_s;
      gnt1_o = req1_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for CPU (m0) and DMA (m1) with bounded DMA lock bursts.
// Define MEM_ARB_RR_EN to use round-robin instead of fixed priority in IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wmask,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wmask,
  input  logic            m1_lock,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int MW = DW / 8;
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_t    state_q;
  logic [CW-1:0] lock_cnt_q;
  logic [CW-1:0] lock_cnt_d;
  logic          rsp_valid_q;
  master_id_t    rsp_id_q;
  master_id_t    rr_last_q;

  logic rr_mode_s;
  logic pick0_s;
  logic pick1_s;
  logic read_gnt_s;

`ifdef MEM_ARB_RR_EN
  assign rr_mode_s = (state_q == IDLE);
`else
  assign rr_mode_s = 1'b0;
`endif

  // m0 is masked only while m1 holds the lock; RELEASE falls back to m0 priority
  arb_pick u_pick (
    .req0_i    (m0_req),
    .req1_i    (m1_req),
    .rr_mode_i (rr_mode_s),
    .rr_last_i (rr_last_q),
    .mask0_i   (state_q != LOCK1),
    .mask1_i   (1'b1),
    .gnt0_o    (pick0_s),
    .gnt1_o    (pick1_s)
  );

  assign m0_gnt = pick0_s & reset;
  assign m1_gnt = pick1_s & reset;

  // Route the granted master's request onto the RAM port
  always_comb begin
    mem_addr  = m0_addr;
    mem_wdata = {DW{1'b0}};
    mem_we    = 1'b0;
    mem_wmask = {MW{1'b0}};
    if (m0_gnt) begin
      mem_wdata = m0_wdata;
      mem_we    = m0_we;
      mem_wmask = m0_we ? m0_wmask : {MW{1'b0}};
    end else if (m1_gnt) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_we;
      mem_wmask = m1_we ? m1_wmask : {MW{1'b0}};
    end else begin
      mem_addr  = m0_addr;
    end
  end

  assign read_gnt_s = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
  assign lock_cnt_d = (lock_cnt_q == CW'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + CW'(1);

  assign m0_rvalid = rsp_valid_q & (rsp_id_q == M_CPU);
  assign m1_rvalid = rsp_valid_q & (rsp_id_q == M_DMA);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  // Lock FSM, read-response tracking and round-robin history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lock_cnt_q  <= {CW{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= M_CPU;
      rr_last_q   <= M_DMA;
    end else begin
      rsp_valid_q <= read_gnt_s;
      rsp_id_q    <= m1_gnt ? M_DMA : M_CPU;
      if (m0_gnt) begin
        rr_last_q <= M_CPU;
      end else if (m1_gnt) begin
        rr_last_q <= M_DMA;
      end
      case (state_q)
        IDLE: begin
          if (m1_gnt && m1_lock) begin
            state_q    <= LOCK1;
            lock_cnt_q <= CW'(1);
          end else begin
            lock_cnt_q <= {CW{1'b0}};
          end
        end
        LOCK1: begin
          if (!m1_req) begin
            state_q    <= IDLE;
            lock_cnt_q <= {CW{1'b0}};
          end else if (m1_gnt) begin
            // Reaching the bound hands the next cycle to the CPU regardless of m1_lock
            if (lock_cnt_d == CW'(MAX_LOCK)) begin
              state_q    <= RELEASE;
              lock_cnt_q <= lock_cnt_d;
            end else if (!m1_lock) begin
              state_q    <= IDLE;
              lock_cnt_q <= {CW{1'b0}};
            end else begin
              lock_cnt_q <= lock_cnt_d;
            end
          end
        end
        RELEASE: begin
          state_q    <= IDLE;
          lock_cnt_q <= {CW{1'b0}};
        end
        default: begin
          state_q    <= IDLE;
          lock_cnt_q <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small byte-maskable RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_wmask;

  logic [31:0] ram [0:4095];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  // Synchronous RAM: byte-masked write, read data one cycle after the address
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) ram[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    mem_rdata <= ram[mem_addr[13:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wmask = 4'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wmask = 4'h0;
    m1_lock = 1'b0;
    #2;
    m0_req = 1'b1; m0_we = 1'b1; m0_wmask = 4'hF;
    #1;
    check_eq("rst_m0_gnt", m0_gnt, 32'd0);
    check_eq("rst_mem_we", mem_we, 32'd0);
    check_eq("rst_mem_wmask", mem_wmask, 32'd0);
    check_eq("rst_m0_rvalid", m0_rvalid, 32'd0);
    m0_req = 1'b0; m0_we = 1'b0;
    tick; tick;
    reset = 1'b1;

`ifdef MEM_ARB_RR_EN
    m0_req = 1'b1; m0_addr = 32'h100;
    m1_req = 1'b1; m1_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_m0_gnt", m0_gnt, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("rr_m1_gnt", m1_gnt, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick;
    end
    m0_req = 1'b0; m1_req = 1'b0;
`else
    // Preload 0x100 through m0, then read it back
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF; m0_wmask = 4'hF;
    #1;
    check_eq("wr_m0_gnt", m0_gnt, 32'd1);
    check_eq("wr_mem_we", mem_we, 32'd1);
    check_eq("wr_mem_wmask", mem_wmask, 32'hF);
    check_eq("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick;
    m0_we = 1'b0;
    #1;
    check_eq("wr_no_rvalid", m0_rvalid, 32'd0);
    check_eq("rd_m0_gnt", m0_gnt, 32'd1);
    check_eq("rd_mem_we", mem_we, 32'd0);
    check_eq("rd_mem_wmask", mem_wmask, 32'd0);
    check_eq("rd_mem_addr", mem_addr, 32'h100);
    tick;
    m0_req = 1'b0;
    #1;
    check_eq("rd_m0_rvalid", m0_rvalid, 32'd1);
    check_eq("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check_eq("rd_m1_rvalid", m1_rvalid, 32'd0);
    check_eq("idle_mem_wdata", mem_wdata, 32'd0);
    check_eq("idle_mem_addr", mem_addr, 32'h100);

    // Conflict in IDLE
    m0_req = 1'b1; m0_addr = 32'h104; m0_wmask = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h200;
    #1;
    check_eq("cf_m0_gnt", m0_gnt, 32'd1);
    check_eq("cf_m1_gnt", m1_gnt, 32'd0);
    tick;
    m0_req = 1'b0;
    #1;
    check_eq("cf_m1_gnt2", m1_gnt, 32'd1);
    check_eq("cf_mem_addr", mem_addr, 32'h200);
    check_eq("cf_m0_rvalid", m0_rvalid, 32'd1);
    tick;
    m1_req = 1'b0;
    #1;
    check_eq("cf_m1_rvalid", m1_rvalid, 32'd1);
    check_eq("cf_m0_rvalid2", m0_rvalid, 32'd0);

    // Lock burst of 4 reads; m0 starts requesting after the first grant
    m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m1_addr = 32'h2000 + 32'(4 * i);
      m1_lock = (i != 3);
      #1;
      check_eq("lb_m1_gnt", m1_gnt, 32'd1);
      check_eq("lb_m0_gnt", m0_gnt, 32'd0);
      if (i > 0) check_eq("lb_m1_rvalid", m1_rvalid, 32'd1);
      tick;
      m0_req = 1'b1;
    end
    m1_req = 1'b0; m1_lock = 1'b0;
    #1;
    check_eq("lb_m0_gnt_after", m0_gnt, 32'd1);
    check_eq("lb_last_rvalid", m1_rvalid, 32'd1);
    tick;
    m0_req = 1'b0;

    // Lock bound: 16 grants then a forced RELEASE cycle for m0
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h2000;
    for (int i = 0; i < 16; i++) begin
      #1;
      check_eq("bd_m1_gnt", m1_gnt, 32'd1);
      check_eq("bd_m0_gnt", m0_gnt, 32'd0);
      tick;
      m0_req = 1'b1;
    end
    #1;
    check_eq("rel_m0_gnt", m0_gnt, 32'd1);
    check_eq("rel_m1_gnt", m1_gnt, 32'd0);
    tick;
    m0_req = 1'b0;
    #1;
    check_eq("regrant_m1", m1_gnt, 32'd1);
    tick;
    m1_req = 1'b0; m1_lock = 1'b0;
    tick;

    // Byte write from m1
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h300; m1_wdata = 32'h0000AB00; m1_wmask = 4'b0010;
    #1;
    check_eq("bw_m1_gnt", m1_gnt, 32'd1);
    check_eq("bw_mem_we", mem_we, 32'd1);
    check_eq("bw_mem_wmask", mem_wmask, 32'h2);
    check_eq("bw_mem_wdata", mem_wdata, 32'h0000AB00);
    tick;
    m1_req = 1'b0; m1_we = 1'b0;
    #1;
    check_eq("bw_m1_rvalid", m1_rvalid, 32'd0);
    check_eq("bw_m0_rvalid", m0_rvalid, 32'd0);

    // Reset while a locked read is in flight
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h2000;
    #1;
    check_eq("ri_m1_gnt", m1_gnt, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ri_gnt_in_rst", m1_gnt, 32'd0);
    tick;
    check_eq("ri_m1_rvalid", m1_rvalid, 32'd0);
    check_eq("ri_m0_rvalid", m0_rvalid, 32'd0);
    reset = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h100;
    #1;
    check_eq("ri_idle_m0_gnt", m0_gnt, 32'd1);
    check_eq("ri_idle_m1_gnt", m1_gnt, 32'd0);
    tick;
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
`endif
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
